// File: rtl/uart_mm_csr.sv
// Avalon-MM register front end for a UART: TX FIFO with fall-through head,
// one-entry RX holding register, sticky error flags and a level interrupt.
module uart_mm_csr #(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 8,
    parameter int ADDR_W   = 4
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [ADDR_W-1:0] avs_address_i,
    input  logic              avs_read_i,
    input  logic              avs_write_i,
    input  logic [DATA_W-1:0] avs_writedata_i,
    output logic [DATA_W-1:0] avs_readdata_o,
    output logic              avs_readdatavalid_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    output logic              irq_o
);
    localparam int PTR_W = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TX_DEPTH);

    localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_LEVEL  = ADDR_W'(4);

    logic [DATA_W-1:0] r_mem [TX_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_avail;
    logic              r_rx_ovr;
    logic              r_tx_drop;
    logic [2:0]        r_ctrl;
    logic [DATA_W-1:0] r_readdata;
    logic              r_readdatavalid;
    logic              r_irq;

    logic              w_wr_txdata;
    logic              w_wr_status;
    logic              w_wr_ctrl;
    logic              w_rd_rxdata;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_rd_mux;

    assign w_wr_txdata = avs_write_i && (avs_address_i == A_TXDATA);
    assign w_wr_status = avs_write_i && (avs_address_i == A_STATUS);
    assign w_wr_ctrl   = avs_write_i && (avs_address_i == A_CTRL);
    assign w_rd_rxdata = avs_read_i  && (avs_address_i == A_RXDATA);

    assign w_tx_full  = (r_count == FULL_CNT);
    assign w_tx_empty = (r_count == '0);
    assign tx_valid_o = !w_tx_empty;
    assign tx_data_o  = r_mem[r_rd_ptr];

    // A write to a full FIFO still fits when the head leaves in the same cycle.
    assign w_pop  = tx_valid_o && tx_ready_i;
    assign w_push = w_wr_txdata && (!w_tx_full || w_pop);
    assign w_drop = w_wr_txdata && w_tx_full && !w_pop;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= avs_writedata_i;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A read of RXDATA racing a new character consumes the old one, so no overrun.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_rx_data  <= '0;
            r_rx_avail <= 1'b0;
            r_rx_ovr   <= 1'b0;
        end else begin
            if (rx_valid_i) begin
                r_rx_data  <= rx_data_i;
                r_rx_avail <= 1'b1;
            end else if (w_rd_rxdata) begin
                r_rx_avail <= 1'b0;
            end
            if (rx_valid_i && r_rx_avail && !w_rd_rxdata) begin
                r_rx_ovr <= 1'b1;
            end else if (w_wr_status && avs_writedata_i[4]) begin
                r_rx_ovr <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_tx_drop <= 1'b0;
            r_ctrl    <= '0;
        end else begin
            if (w_drop) begin
                r_tx_drop <= 1'b1;
            end else if (w_wr_status && avs_writedata_i[3]) begin
                r_tx_drop <= 1'b0;
            end
            if (w_wr_ctrl) begin
                r_ctrl <= avs_writedata_i[2:0];
            end
        end
    end

    assign w_status = DATA_W'({r_rx_ovr, r_tx_drop, r_rx_avail, w_tx_empty, w_tx_full});

    always_comb begin
        w_rd_mux = '0;
        case (avs_address_i)
            A_STATUS: w_rd_mux = w_status;
            A_RXDATA: w_rd_mux = r_rx_data;
            A_CTRL:   w_rd_mux = DATA_W'(r_ctrl);
            A_LEVEL:  w_rd_mux = DATA_W'(r_count);
            default:  w_rd_mux = '0;
        endcase
    end

    // Read data is taken from pre-edge state, so a simultaneous write is not visible.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
            r_irq           <= 1'b0;
        end else begin
            r_readdatavalid <= avs_read_i;
            if (avs_read_i) begin
                r_readdata <= w_rd_mux;
            end
            r_irq <= (r_ctrl[0] & w_tx_empty)
                   | (r_ctrl[1] & r_rx_avail)
                   | (r_ctrl[2] & (r_tx_drop | r_rx_ovr));
        end
    end

    assign avs_readdata_o      = r_readdata;
    assign avs_readdatavalid_o = r_readdatavalid;
    assign irq_o               = r_irq;

endmodule

// File: tb/tb_uart_mm_csr.sv
// Randomized and directed bench for uart_mm_csr against a queue-based reference model.
module tb_uart_mm_csr;
    localparam int DATA_W   = 8;
    localparam int TX_DEPTH = 8;
    localparam int ADDR_W   = 4;

    logic              clk_i = 1'b0;
    logic              arst_n_i = 1'b0;
    logic [ADDR_W-1:0] avs_address_i = '0;
    logic              avs_read_i = 1'b0;
    logic              avs_write_i = 1'b0;
    logic [DATA_W-1:0] avs_writedata_i = '0;
    logic [DATA_W-1:0] avs_readdata_o;
    logic              avs_readdatavalid_o;
    logic [DATA_W-1:0] tx_data_o;
    logic              tx_valid_o;
    logic              tx_ready_i = 1'b0;
    logic [DATA_W-1:0] rx_data_i = '0;
    logic              rx_valid_i = 1'b0;
    logic              irq_o;

    uart_mm_csr #(.DATA_W(DATA_W), .TX_DEPTH(TX_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i               (clk_i),
        .arst_n_i            (arst_n_i),
        .avs_address_i       (avs_address_i),
        .avs_read_i          (avs_read_i),
        .avs_write_i         (avs_write_i),
        .avs_writedata_i     (avs_writedata_i),
        .avs_readdata_o      (avs_readdata_o),
        .avs_readdatavalid_o (avs_readdatavalid_o),
        .tx_data_o           (tx_data_o),
        .tx_valid_o          (tx_valid_o),
        .tx_ready_i          (tx_ready_i),
        .rx_data_i           (rx_data_i),
        .rx_valid_i          (rx_valid_i),
        .irq_o               (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_rx_hold;
    bit         m_rx_avail, m_drop, m_ovr, m_rdv, m_irq;
    logic [2:0] m_ctrl;
    logic [7:0] m_rd;

    task automatic m_reset();
        m_q.delete();
        m_rx_hold = '0; m_rx_avail = 0; m_drop = 0; m_ovr = 0;
        m_ctrl = '0; m_rd = '0; m_rdv = 0; m_irq = 0;
    endtask

    function automatic logic [7:0] m_read_val(input logic [3:0] a);
        case (a)
            4'd1:    return {3'b000, m_ovr, m_drop, m_rx_avail,
                             m_q.size() == 0, m_q.size() == TX_DEPTH};
            4'd2:    return m_rx_hold;
            4'd3:    return {5'b0, m_ctrl};
            4'd4:    return 8'(m_q.size());
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit m_irq_fn();
        return (m_ctrl[0] && m_q.size() == 0) || (m_ctrl[1] && m_rx_avail)
            || (m_ctrl[2] && (m_drop || m_ovr));
    endfunction

    // One clock: evaluate the model on the current inputs, advance, compare outputs.
    task automatic step(input string tag);
        logic [7:0] rv;
        bit irq_n, full, pop, wr_tx, push, rd_rx, wr_st;
        rv    = m_read_val(avs_address_i);
        irq_n = m_irq_fn();
        full  = (m_q.size() == TX_DEPTH);
        pop   = (m_q.size() != 0) && tx_ready_i;
        wr_tx = avs_write_i && avs_address_i == 4'd0;
        push  = wr_tx && (!full || pop);
        rd_rx = avs_read_i && avs_address_i == 4'd2;
        wr_st = avs_write_i && avs_address_i == 4'd1;
        if (wr_tx && !push) m_drop = 1;
        else if (wr_st && avs_writedata_i[3]) m_drop = 0;
        if (rx_valid_i && m_rx_avail && !rd_rx) m_ovr = 1;
        else if (wr_st && avs_writedata_i[4]) m_ovr = 0;
        if (rx_valid_i) begin
            m_rx_hold = rx_data_i;
            m_rx_avail = 1;
        end else if (rd_rx) begin
            m_rx_avail = 0;
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(avs_writedata_i);
        if (avs_write_i && avs_address_i == 4'd3) m_ctrl = avs_writedata_i[2:0];
        m_rdv = avs_read_i;
        if (avs_read_i) m_rd = rv;
        m_irq = irq_n;
        @(posedge clk_i);
        #1;
        chk({tag, "/rdv"}, avs_readdatavalid_o, m_rdv);
        chk({tag, "/rdata"}, avs_readdata_o, m_rd);
        chk({tag, "/txv"}, tx_valid_o, m_q.size() != 0);
        if (m_q.size() != 0) chk({tag, "/txd"}, tx_data_o, m_q[0]);
        chk({tag, "/irq"}, irq_o, m_irq);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step("idle");
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        avs_address_i = a; avs_writedata_i = d; avs_write_i = 1'b1;
        step("wr");
        avs_write_i = 1'b0;
        $display("WR  addr=%0d data=0x%02h", a, d);
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        avs_address_i = a; avs_read_i = 1'b1;
        step("rd");
        avs_read_i = 1'b0;
        d = avs_readdata_o;
        $display("RD  addr=%0d data=0x%02h", a, d);
    endtask

    task automatic rx(input logic [7:0] d);
        rx_data_i = d; rx_valid_i = 1'b1;
        step("rx");
        rx_valid_i = 1'b0;
        $display("RX  data=0x%02h", d);
    endtask

    initial begin
        logic [7:0] d;
        m_reset();
        #12;
        chk("rst_txv", tx_valid_o, 0);
        chk("rst_rdv", avs_readdatavalid_o, 0);
        chk("rst_rdata", avs_readdata_o, 0);
        chk("rst_irq", irq_o, 0);
        @(posedge clk_i); #1;
        arst_n_i = 1'b1;
        rd(4'd1, d); chk("rst_status", d, 8'h02);
        rd(4'd3, d); chk("rst_ctrl", d, 8'h00);
        rd(4'd4, d); chk("rst_level", d, 8'h00);

        // Fill and overflow
        tx_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) wr(4'd0, 8'(8'h11 + i));
        rd(4'd4, d); chk("fill_level", d, 8'd8);
        rd(4'd1, d); chk("fill_full", d[0], 1);
        wr(4'd0, 8'h99);
        rd(4'd1, d); chk("fill_drop", d[3], 1);

        // Drain in order, one word per cycle
        tx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", tx_valid_o, 1);
            chk("drain_data", tx_data_o, 8'(8'h11 + i));
            step("drain");
        end
        chk("drain_empty", tx_valid_o, 0);
        tx_ready_i = 1'b0;
        rd(4'd4, d); chk("drain_level", d, 8'd0);
        wr(4'd1, 8'h18);
        rd(4'd1, d); chk("w1c_status", d, 8'h02);

        // Full with same-cycle pop accepts the write
        for (int i = 0; i < 8; i++) wr(4'd0, 8'($urandom));
        tx_ready_i = 1'b1;
        wr(4'd0, 8'hAA);
        tx_ready_i = 1'b0;
        rd(4'd4, d); chk("bnd_level", d, 8'd8);
        rd(4'd1, d); chk("bnd_nodrop", d[3], 0);
        tx_ready_i = 1'b1;
        idle(7);
        chk("bnd_tail", tx_data_o, 8'hAA);
        idle(1);
        tx_ready_i = 1'b0;

        // RX overrun and clear
        rx(8'h5A);
        rx(8'h3C);
        rd(4'd2, d); chk("rx_data", d, 8'h3C);
        rd(4'd1, d); chk("rx_status", d, 8'h12);
        wr(4'd1, 8'h10);
        rd(4'd1, d); chk("rx_ovr_clr", d[4], 0);

        // Interrupt on RX available
        wr(4'd3, 8'h02);
        rx(8'h66);
        idle(1);
        chk("irq_set", irq_o, 1);
        rd(4'd2, d);
        idle(1);
        chk("irq_clr", irq_o, 0);
        wr(4'd3, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: avs_address_i = 4'd0;
                4:          avs_address_i = 4'd1;
                5:          avs_address_i = 4'd2;
                6:          avs_address_i = 4'd3;
                7:          avs_address_i = 4'd4;
                8:          avs_address_i = 4'($urandom_range(5, 7));
                default:    avs_address_i = 4'd15;
            endcase
            avs_write_i     = ($urandom_range(0, 99) < 45);
            avs_read_i      = ($urandom_range(0, 99) < 35);
            avs_writedata_i = 8'($urandom);
            tx_ready_i      = ($urandom_range(0, 99) < (((i / 300) % 2 == 0) ? 10 : 60));
            rx_valid_i      = ($urandom_range(0, 99) < 15);
            rx_data_i       = 8'($urandom);
            step("rnd");
        end
        avs_write_i = 1'b0; avs_read_i = 1'b0; rx_valid_i = 1'b0; tx_ready_i = 1'b0;
        $display("RND 3000 cycles done");

        // Asynchronous reset in the middle of a fill
        wr(4'd3, 8'h02);
        tx_ready_i = 1'b1;
        idle(TX_DEPTH);
        tx_ready_i = 1'b0;
        rx(8'h44);
        for (int i = 0; i < 5; i++) wr(4'd0, 8'(8'h20 + i));
        rd(4'd4, d); chk("pre_rst_level", d, 8'd5);
        idle(1);
        chk("pre_rst_irq", irq_o, 1);
        #2;
        arst_n_i = 1'b0;
        #1;
        m_reset();
        chk("arst_txv", tx_valid_o, 0);
        chk("arst_irq", irq_o, 0);
        chk("arst_rdv", avs_readdatavalid_o, 0);
        chk("arst_rdata", avs_readdata_o, 0);
        @(posedge clk_i); #1;
        chk("arst_hold_txv", tx_valid_o, 0);
        arst_n_i = 1'b1;
        rd(4'd4, d);
        chk("post_rst_rdv", avs_readdatavalid_o, 1);
        chk("post_rst_level", d, 8'd0);
        wr(4'd0, 8'h77);
        wr(4'd0, 8'h78);
        chk("post_rst_head", tx_data_o, 8'h77);
        tx_ready_i = 1'b1;
        idle(3);
        tx_ready_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_mm_csr.md
UART_MM_CSR -- requirements
Module: uart_mm_csr

Interface
REQ-001 SHALL have parameter DATA_W, default 8, character and data-bus width (5..16).
REQ-002 SHALL have parameter TX_DEPTH, default 8, TX FIFO depth (power of 2, >= 2).
REQ-003 SHALL have parameter ADDR_W, default 4, Avalon-MM word-address width.
REQ-004 SHALL have ports, one per line (name direction width meaning):
  clk_i  in  1  clock; all logic on rising edge
  arst_n_i  in  1  reset, asynchronous, active-low
  avs_address_i  in  ADDR_W  register address
  avs_read_i  in  1  read strobe
  avs_write_i  in  1  write strobe
  avs_writedata_i  in  DATA_W  write data
  avs_readdata_o  out  DATA_W  read data
  avs_readdatavalid_o  out  1  read data valid
  tx_data_o  out  DATA_W  TX FIFO head, to transmitter
  tx_valid_o  out  1  TX FIFO non-empty
  tx_ready_i  in  1  transmitter accepts head
  rx_data_i  in  DATA_W  received character
  rx_valid_i  in  1  one-cycle strobe, rx_data_i valid
  irq_o  out  1  level interrupt

Function
REQ-005 SHALL decode the register map: 0x0 TXDATA (W), 0x1 STATUS (R/W1C), 0x2 RXDATA (R), 0x3 CTRL (R/W), 0x4 LEVEL (R); other addresses: reads return 0, writes ignored.
REQ-006 SHALL return STATUS bits: [0] tx_full, [1] tx_empty, [2] rx_avail, [3] tx_drop (sticky), [4] rx_ovr (sticky); upper bits 0.
REQ-007 SHALL have CTRL bits [0] ie_tx_empty, [1] ie_rx, [2] ie_err; upper bits read 0.
REQ-008 SHALL return in LEVEL the TX FIFO occupancy, 0..TX_DEPTH, zero-extended.
REQ-009 SHALL register read data: avs_readdata_o and avs_readdatavalid_o=1 in the cycle after avs_read_i; readdatavalid=0 otherwise; readdata holds its last value when no read occurs.
REQ-010 SHALL push avs_writedata_i into the TX FIFO on a write to 0x0 when not full, or when full with a pop in the same cycle.
REQ-011 SHALL discard a write to 0x0 when full and not popping, and set tx_drop.
REQ-012 SHALL pop the FIFO when tx_valid_o && tx_ready_i; tx_data_o = head (first-word fall-through).
REQ-013 SHALL leave occupancy unchanged on a simultaneous push and pop; empty+push gives tx_valid_o=1 on the next cycle.
REQ-014 SHALL wrap the read and write pointers modulo TX_DEPTH.
REQ-015 SHALL capture rx_data_i into a one-entry RX holding register on rx_valid_i and set rx_avail.
REQ-016 SHALL, on rx_valid_i while rx_avail=1, overwrite the holding register, set rx_ovr, and keep rx_avail=1.
REQ-017 SHALL clear rx_avail on a read of 0x2; a read and rx_valid_i in the same cycle returns the old data, loads the new data, leaves rx_avail=1, and does not set rx_ovr.
REQ-018 SHALL clear tx_drop/rx_ovr on a write of 1 to STATUS bit 3/4; a same-cycle set event wins over the clear.
REQ-019 SHALL drive irq_o registered = (ie_tx_empty & tx_empty) | (ie_rx & rx_avail) | (ie_err & (tx_drop | rx_ovr)).
REQ-020 SHALL treat avs_read_i and avs_write_i asserted together as a write plus a read; the read returns the pre-write value.

Reset
REQ-021 SHALL, on arst_n_i low, immediately clear the FIFO pointers and count, RX register, rx_avail, sticky bits, CTRL, avs_readdata_o, avs_readdatavalid_o, tx_valid_o and irq_o; tx_empty=1.
REQ-022 SHALL discard in-flight FIFO contents on reset mid-operation; after release the first pushed word is the first popped.

Verification
REQ-023 Fill: tx_ready_i=0, write 0x11..0x18 to 0x0 (8 writes) -> LEVEL=8, STATUS[0]=1; a 9th write of 0x99 -> dropped, STATUS[3]=1.
REQ-024 Drain: tx_ready_i=1 after fill -> tx_data_o 0x11..0x18 on consecutive cycles, then tx_valid_o=0, LEVEL=0.
REQ-025 Full boundary: FIFO full, write 0xAA with a pop in the same cycle -> accepted, LEVEL stays 8, tx_drop stays 0.
REQ-026 RX: rx_valid_i with 0x5A, then 0x3C -> read 0x2 returns 0x3C, STATUS=0x12 with TX empty; write 0x10 to 0x1 -> STATUS[4]=0.
REQ-027 IRQ: CTRL=0x2, rx_valid_i -> irq_o=1 within 2 cycles; read 0x2 -> irq_o=0 within 2 cycles.
REQ-028 Reset mid-fill (LEVEL=5) -> all outputs 0, LEVEL=0 in the next read; read latency is 1 cycle after release.
